// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch stage: word type, NOP word,
// fetch FSM state encodings and the PC+4 adder also used by decode.
package fetch_unit_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t ZERO = '0;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    // Wraps modulo 2^32; decode uses the same adder for its branch base.
    function automatic word_t pc_plus4(input word_t a);
        return a + word_t'(4);
    endfunction

    function automatic word_t align_word(input word_t a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake, parks one
// returned instruction during stalls and squashes in-flight fetches on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] nPC_if,
    output logic [WORD_W-1:0] IR_if,
    output logic              valid_if
);

    fetch_state_t state_reg, state_next;
    word_t        pc_reg, pc_next;
    word_t        req_addr_reg, req_addr_next;
    word_t        skid_ir_reg, skid_ir_next;
    word_t        skid_npc_reg, skid_npc_next;
    word_t        npc_reg, npc_next;
    word_t        ir_reg, ir_next;
    logic         valid_reg, valid_next;

    word_t        req_npc;
    word_t        target_pc;

    assign req_npc   = pc_plus4(req_addr_reg);
    assign target_pc = align_word(redirect_pc);

    assign imem_req  = (state_reg != S_HOLD);
    assign imem_addr = req_addr_reg;
    assign nPC_if    = npc_reg;
    assign IR_if     = ir_reg;
    assign valid_if  = valid_reg;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_addr_next = req_addr_reg;
        skid_ir_next  = skid_ir_reg;
        skid_npc_next = skid_npc_reg;
        npc_next      = npc_reg;
        ir_next       = ir_reg;
        valid_next    = valid_reg;

        if (redirect) begin
            npc_next      = ZERO;
            ir_next       = ZERO;
            valid_next    = 1'b0;
            pc_next       = target_pc;
            skid_ir_next  = ZERO;
            skid_npc_next = ZERO;
            unique case (state_reg)
                S_REQ: begin
                    if (imem_ack) begin
                        req_addr_next = target_pc;
                        state_next    = S_REQ;
                    end else begin
                        state_next    = S_DRAIN;
                    end
                end
                S_HOLD: begin
                    req_addr_next = target_pc;
                    state_next    = S_REQ;
                end
                default: begin
                    // A stale ack landing with the redirect ends the drain right away.
                    if (imem_ack) begin
                        req_addr_next = target_pc;
                        state_next    = S_REQ;
                    end else begin
                        state_next    = S_DRAIN;
                    end
                end
            endcase
        end else begin
            unique case (state_reg)
                S_REQ: begin
                    if (stall) begin
                        if (imem_ack) begin
                            skid_ir_next  = imem_rdata;
                            skid_npc_next = req_npc;
                            pc_next       = req_npc;
                            state_next    = S_HOLD;
                        end
                    end else if (imem_ack) begin
                        ir_next       = imem_rdata;
                        npc_next      = req_npc;
                        valid_next    = 1'b1;
                        pc_next       = req_npc;
                        req_addr_next = req_npc;
                    end else begin
                        ir_next       = ZERO;
                        npc_next      = ZERO;
                        valid_next    = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ir_next       = skid_ir_reg;
                        npc_next      = skid_npc_reg;
                        valid_next    = 1'b1;
                        req_addr_next = pc_reg;
                        state_next    = S_REQ;
                    end
                end
                default: begin
                    ir_next    = ZERO;
                    npc_next   = ZERO;
                    valid_next = 1'b0;
                    if (imem_ack) begin
                        req_addr_next = pc_reg;
                        state_next    = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            req_addr_reg <= RESET_PC;
            skid_ir_reg  <= ZERO;
            skid_npc_reg <= ZERO;
            npc_reg      <= ZERO;
            ir_reg       <= ZERO;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_addr_reg <= req_addr_next;
            skid_ir_reg  <= skid_ir_next;
            skid_npc_reg <= skid_npc_next;
            npc_reg      <= npc_next;
            ir_reg       <= ir_next;
            valid_reg    <= valid_next;
        end
    end

endmodule
